tcm_prog_loader: RTL and testbench

Synthesizable program-load and run sequencer in front of `riscv_tcm_top`. It accepts a stream of 32-bit instruction words and writes them into TCM through the `tb_inst_*` write port at incrementing addresses. It then pulses the CPU reset and monitors the issue-stage PC for a programmable end address, with a drain window and a cycle-limit timeout. It is parametrised in base address, trace depth, reset width, drain length and cycle limit.

---
 rtl/tcm_prog_loader.sv | 154 +++++++++++++++
 tb/tb_tcm_prog_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_prog_loader.sv
// rtl/tcm_prog_loader.sv - streams a program into TCM, pulses CPU reset, then watches the PC for the end address.
// Optional build macro TCM_LOADER_CHECKSUM_EN adds a running sum of the loaded words on checksum_o.
module tcm_prog_loader #(
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter int          DEPTH_W      = 16,
  parameter int          RST_CYCLES   = 1,
  parameter int          DRAIN_CYCLES = 50,
  parameter int          MAX_CYCLES   = 40000,
  parameter int          CYC_W        = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [DEPTH_W-1:0] load_len_i,
  input  logic [31:0]        end_pc_i,
  input  logic               s_valid_i,
  input  logic [31:0]        s_data_i,
  output logic               s_ready_o,
  output logic [3:0]         tb_inst_we_o,
  output logic [31:0]        tb_inst_addr_o,
  output logic [31:0]        tb_inst_data_o,
  output logic               rst_cpu_o,
  input  logic [31:0]        pc_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [CYC_W-1:0]   cycles_o,
  output logic [31:0]        checksum_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CRST, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state;
  logic [DEPTH_W-1:0] len_q;
  logic [DEPTH_W-1:0] idx;
  logic [31:0]        end_pc_q;
  logic [31:0]        rst_cnt;
  logic [31:0]        drain_cnt;
  logic [DEPTH_W:0]   idx_nxt;
  logic               last_word;

  // One bit wider so the last-word compare cannot alias on a full-depth load.
  assign idx_nxt   = {1'b0, idx} + (DEPTH_W+1)'(1);
  assign last_word = (idx_nxt == {1'b0, len_q});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      len_q          <= '0;
      idx            <= '0;
      end_pc_q       <= '0;
      rst_cnt        <= '0;
      drain_cnt      <= '0;
      s_ready_o      <= 1'b0;
      tb_inst_we_o   <= 4'h0;
      tb_inst_addr_o <= '0;
      tb_inst_data_o <= '0;
      rst_cpu_o      <= 1'b1;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      timeout_o      <= 1'b0;
      cycles_o       <= '0;
`ifdef TCM_LOADER_CHECKSUM_EN
      checksum_o     <= '0;
`endif
    end else begin
      tb_inst_we_o <= 4'h0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            len_q     <= load_len_i;
            end_pc_q  <= end_pc_i;
            idx       <= '0;
            rst_cnt   <= '0;
            cycles_o  <= '0;
            timeout_o <= 1'b0;
            done_o    <= 1'b0;
            busy_o    <= 1'b1;
            rst_cpu_o <= 1'b1;
`ifdef TCM_LOADER_CHECKSUM_EN
            checksum_o <= '0;
`endif
            if (load_len_i != '0) begin
              state     <= S_LOAD;
              s_ready_o <= 1'b1;
            end else begin
              state <= S_CRST;
            end
          end
        end
        S_LOAD: begin
          if (s_valid_i && s_ready_o) begin
            tb_inst_we_o   <= 4'hf;
            tb_inst_addr_o <= ADDR_BASE + (32'(idx) << 2);
            tb_inst_data_o <= s_data_i;
            idx            <= idx_nxt[DEPTH_W-1:0];
`ifdef TCM_LOADER_CHECKSUM_EN
            checksum_o     <= checksum_o + s_data_i;
`endif
            if (last_word) begin
              state     <= S_CRST;
              s_ready_o <= 1'b0;
            end
          end
        end
        S_CRST: begin
          if (rst_cnt == 32'(RST_CYCLES - 1)) begin
            state     <= S_RUN;
            rst_cpu_o <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 32'd1;
          end
        end
        S_RUN: begin
          // A PC match takes priority over the cycle limit in the same cycle.
          if (pc_i == end_pc_q) begin
            cycles_o  <= cycles_o + CYC_W'(1);
            drain_cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              state  <= S_DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state <= S_DRAIN;
            end
          end else if (cycles_o == CYC_W'(MAX_CYCLES - 1)) begin
            state     <= S_DONE;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            timeout_o <= 1'b1;
          end else begin
            cycles_o <= cycles_o + CYC_W'(1);
          end
        end
        S_DRAIN: begin
          cycles_o <= cycles_o + CYC_W'(1);
          if (drain_cnt == 32'(DRAIN_CYCLES - 1)) begin
            state  <= S_DONE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef TCM_LOADER_CHECKSUM_EN
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_tcm_prog_loader.sv
// tb/tb_tcm_prog_loader.sv - randomized self-checking bench for tcm_prog_loader.
module tb_tcm_prog_loader;

  localparam logic [31:0] ADDR_BASE    = 32'hFFFF_FFF4;
  localparam int          DEPTH_W      = 8;
  localparam int          RST_CYCLES   = 3;
  localparam int          DRAIN_CYCLES = 50;
  localparam int          MAX_CYCLES   = 100;
  localparam int          CYC_W        = 16;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               start_i = 1'b0;
  logic [DEPTH_W-1:0] load_len_i = '0;
  logic [31:0]        end_pc_i = '0;
  logic               s_valid_i = 1'b0;
  logic [31:0]        s_data_i = '0;
  logic               s_ready_o;
  logic [3:0]         tb_inst_we_o;
  logic [31:0]        tb_inst_addr_o;
  logic [31:0]        tb_inst_data_o;
  logic               rst_cpu_o;
  logic [31:0]        pc_i = '0;
  logic               busy_o;
  logic               done_o;
  logic               timeout_o;
  logic [CYC_W-1:0]   cycles_o;
  logic [31:0]        checksum_o;

  int checks = 0;
  int errors = 0;

  tcm_prog_loader #(
    .ADDR_BASE(ADDR_BASE), .DEPTH_W(DEPTH_W), .RST_CYCLES(RST_CYCLES),
    .DRAIN_CYCLES(DRAIN_CYCLES), .MAX_CYCLES(MAX_CYCLES), .CYC_W(CYC_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .load_len_i(load_len_i),
    .end_pc_i(end_pc_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .tb_inst_we_o(tb_inst_we_o), .tb_inst_addr_o(tb_inst_addr_o), .tb_inst_data_o(tb_inst_data_o),
    .rst_cpu_o(rst_cpu_o), .pc_i(pc_i), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .cycles_o(cycles_o), .checksum_o(checksum_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    checks++;
    if ({s_ready_o, tb_inst_we_o, busy_o, done_o, timeout_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%0b we=%h busy=%0b done=%0b to=%0b exp all 0",
               s_ready_o, tb_inst_we_o, busy_o, done_o, timeout_o);
    end
    checks++;
    if (rst_cpu_o !== 1'b1) begin
      errors++; $display("FAIL reset_rst_cpu got %0b exp 1", rst_cpu_o);
    end
    checks++;
    if ({tb_inst_addr_o, tb_inst_data_o, checksum_o} !== 96'h0 || cycles_o !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h data=%h sum=%h cyc=%0d exp 0",
               tb_inst_addr_o, tb_inst_data_o, checksum_o, cycles_o);
    end
  endtask

  // mode 0: valid always high, 1: valid toggles 1,0,1,0..., 2: random valid
  task automatic test_load_and_run(input string name, input int len, input int mode, input int match_at);
    logic [31:0] epc, sum, exp_sum, exp_addr, exp_data;
    logic [CYC_W-1:0] cyc_done;
    int n_acc, it, n, k, exp_ticks, exp_cycles;
    bit v, exp_to;

    epc = $urandom & 32'hFFFF_FFFC;
    sum = 32'h0;
    start_i = 1'b1;
    load_len_i = DEPTH_W'(len);
    end_pc_i = epc;
    tick();
    start_i = 1'b0;
    load_len_i = DEPTH_W'($urandom);
    end_pc_i = $urandom;

    checks++;
    if ({busy_o, done_o, timeout_o, rst_cpu_o} !== 4'b1001 || cycles_o !== '0) begin
      errors++;
      $display("FAIL %s start_state got busy=%0b done=%0b to=%0b rst_cpu=%0b cyc=%0d exp 1,0,0,1,0",
               name, busy_o, done_o, timeout_o, rst_cpu_o, cycles_o);
    end
    checks++;
    if (s_ready_o !== (len != 0)) begin
      errors++; $display("FAIL %s start_ready got %0b exp %0b", name, s_ready_o, len != 0);
    end

    n_acc = 0;
    it = 0;
    while (n_acc < len && it < 8 * len + 20) begin
      case (mode)
        0: v = 1'b1;
        1: v = (it % 2 == 0);
        default: v = 1'($urandom);
      endcase
      s_valid_i = v;
      s_data_i = $urandom;
      exp_addr = ADDR_BASE + 32'(n_acc * 4);
      exp_data = s_data_i;
      if (s_ready_o !== 1'b1) begin
        checks++; errors++;
        $display("FAIL %s load_ready got %0b exp 1 at word %0d", name, s_ready_o, n_acc);
      end
      tick();
      it++;
      checks++;
      if (v) begin
        if (tb_inst_we_o !== 4'hf || tb_inst_addr_o !== exp_addr || tb_inst_data_o !== exp_data) begin
          errors++;
          $display("FAIL %s write%0d got we=%h addr=%h data=%h exp we=f addr=%h data=%h",
                   name, n_acc, tb_inst_we_o, tb_inst_addr_o, tb_inst_data_o, exp_addr, exp_data);
        end
        sum = sum + exp_data;
        n_acc++;
      end else if (tb_inst_we_o !== 4'h0) begin
        errors++; $display("FAIL %s bubble_write got we=%h exp 0", name, tb_inst_we_o);
      end
    end
    s_valid_i = 1'b0;
    if (n_acc < len) begin
      checks++; errors++;
      $display("FAIL %s load_stall got %0d words exp %0d", name, n_acc, len);
    end

    checks++;
    if (s_ready_o !== 1'b0 || rst_cpu_o !== 1'b1) begin
      errors++;
      $display("FAIL %s crst_entry got ready=%0b rst_cpu=%0b exp 0,1", name, s_ready_o, rst_cpu_o);
    end
`ifdef TCM_LOADER_CHECKSUM_EN
    exp_sum = sum;
`else
    exp_sum = 32'h0;
`endif
    checks++;
    if (checksum_o !== exp_sum) begin
      errors++; $display("FAIL %s checksum got %h exp %h", name, checksum_o, exp_sum);
    end

    n = 0;
    while (rst_cpu_o === 1'b1 && n < 50) begin
      tick();
      if (tb_inst_we_o !== 4'h0) begin
        checks++; errors++;
        $display("FAIL %s crst_write got we=%h exp 0", name, tb_inst_we_o);
      end
      n++;
    end
    checks++;
    if (n != RST_CYCLES) begin
      errors++; $display("FAIL %s rst_cpu_width got %0d exp %0d", name, n, RST_CYCLES);
    end

    if (match_at >= 0 && match_at <= MAX_CYCLES - 1) begin
      exp_ticks = match_at + DRAIN_CYCLES + 1;
      exp_cycles = exp_ticks;
      exp_to = 1'b0;
    end else begin
      exp_ticks = MAX_CYCLES;
      exp_cycles = MAX_CYCLES - 1;
      exp_to = 1'b1;
    end

    k = 0;
    while (done_o !== 1'b1 && k < 400) begin
      pc_i = (k == match_at) ? epc : (epc ^ (32'd1 + ($urandom % 255)));
      start_i = (k == 5);
      load_len_i = DEPTH_W'($urandom);
      tick();
      start_i = 1'b0;
      k++;
    end

    checks++;
    if (k != exp_ticks) begin
      errors++; $display("FAIL %s done_latency got %0d exp %0d", name, k, exp_ticks);
    end
    checks++;
    if (timeout_o !== exp_to || cycles_o !== CYC_W'(exp_cycles)) begin
      errors++;
      $display("FAIL %s run_result got to=%0b cyc=%0d exp to=%0b cyc=%0d",
               name, timeout_o, cycles_o, exp_to, exp_cycles);
    end
    checks++;
    if ({busy_o, rst_cpu_o, s_ready_o} !== 3'b000 || checksum_o !== exp_sum) begin
      errors++;
      $display("FAIL %s done_state got busy=%0b rst_cpu=%0b ready=%0b sum=%h exp 0,0,0 sum=%h",
               name, busy_o, rst_cpu_o, s_ready_o, checksum_o, exp_sum);
    end

    cyc_done = cycles_o;
    tick(); tick(); tick();
    checks++;
    if (cycles_o !== CYC_W'(exp_cycles) || done_o !== 1'b1) begin
      errors++;
      $display("FAIL %s done_hold got cyc=%0d done=%0b exp cyc=%0d done=1 (was %0d)",
               name, cycles_o, done_o, exp_cycles, cyc_done);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] d;
    start_i = 1'b1;
    load_len_i = DEPTH_W'(5);
    end_pc_i = $urandom;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid_i = 1'b1;
      d = $urandom;
      s_data_i = d;
      tick();
      checks++;
      if (tb_inst_we_o !== 4'hf || tb_inst_addr_o !== ADDR_BASE + 32'(i * 4) || tb_inst_data_o !== d) begin
        errors++;
        $display("FAIL midrst_write%0d got we=%h addr=%h data=%h exp f %h %h",
                 i, tb_inst_we_o, tb_inst_addr_o, tb_inst_data_o, ADDR_BASE + 32'(i * 4), d);
      end
    end
    s_data_i = $urandom;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    s_valid_i = 1'b0;
    checks++;
    if (tb_inst_we_o !== 4'h0 || rst_cpu_o !== 1'b1 || s_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got we=%h rst_cpu=%0b ready=%0b busy=%0b exp 0,1,0,0",
               tb_inst_we_o, rst_cpu_o, s_ready_o, busy_o);
    end
    tick();
    checks++;
    if (s_ready_o !== 1'b0 || busy_o !== 1'b0 || tb_inst_we_o !== 4'h0) begin
      errors++;
      $display("FAIL midrst_idle got ready=%0b busy=%0b we=%h exp 0,0,0", s_ready_o, busy_o, tb_inst_we_o);
    end
  endtask

  initial begin
    test_reset();
    test_load_and_run("burst", 3, 0, 10);
    test_load_and_run("bubbles", 2, 1, 0);
    test_load_and_run("timeout", 1, 0, -1);
    test_load_and_run("limit_match", 0, 0, MAX_CYCLES - 1);
    test_load_and_run("wrap", 4, 2, $urandom_range(0, 60));
    test_reset_mid_load();
    test_load_and_run("reload", 5, 0, 3);
    for (int r = 0; r < 3; r++)
      test_load_and_run("random", $urandom_range(1, 6), 2, $urandom_range(0, 120));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
